// File: rtl/sa_cache_pkg.sv
// Shared widths, tag-entry type and counter helper for sa_cache.
// Optional feature macro: SA_CACHE_EVICT_COUNT_EN.
package sa_cache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_SETS   = 64;
  localparam int DEF_WAYS   = 4;
  localparam int DEF_BLOCK  = 16;
  localparam int TAG_MAX    = 64;

  localparam int OFF_W = $clog2(DEF_BLOCK);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - OFF_W - IDX_W;
  localparam int AGE_W = $clog2(DEF_WAYS);

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
  } tag_entry_t;

  // At least one bit, so one-set / one-way builds still get a select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= mx) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sa_cache_lru.sv
// Per-set true-LRU age update and victim choice.
// Ages stay a permutation of 0..WAYS-1.
module sa_cache_lru
  import sa_cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int AW   = 2
) (
  input  logic [WAYS-1:0][AW-1:0] ages,
  input  logic [WAYS-1:0]         valid,
  input  logic [WAYS-1:0]         hitv,
  output logic [WAYS-1:0][AW-1:0] nxt_ages,
  output logic [AW-1:0]           victim
);

  logic [AW-1:0] inv_w;
  logic [AW-1:0] lru_w;
  logic [AW-1:0] acc;
  logic [AW-1:0] old;

  always_comb begin
    inv_w    = '0;
    lru_w    = '0;
    acc      = '0;
    old      = '0;
    victim   = '0;
    nxt_ages = ages;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) inv_w = AW'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (ages[w] == AW'(WAYS - 1)) lru_w = AW'(w);
    end
    victim = (&valid) ? lru_w : inv_w;
    acc = victim;
    for (int w = 0; w < WAYS; w++) begin
      if (hitv[w]) acc = AW'(w);
    end
    old = ages[acc];
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == acc)
        nxt_ages[w] = '0;
      else if (ages[w] < old)
        nxt_ages[w] = ages[w] + AW'(1);
      else
        nxt_ages[w] = ages[w];
    end
  end

endmodule

// File: rtl/sa_cache.sv
// N-way set-associative tag-only cache model with true-LRU and stats.
// SA_CACHE_EVICT_COUNT_EN enables the eviction counter.
module sa_cache
  import sa_cache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] address,
  output logic              resp_valid,
  output logic              hit,
  output logic              miss,
  output logic [CNT_W-1:0]  hitCount,
  output logic [CNT_W-1:0]  missCount,
  output logic [CNT_W-1:0]  evictCount
);

  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int IB = $clog2(SETS);
  localparam int IW = sel_w(SETS);
  localparam int AW = sel_w(WAYS);

  tag_entry_t                ent [SETS][WAYS];
  logic [WAYS-1:0][AW-1:0]   age [SETS];

  logic [IW-1:0]           idx;
  logic [TAG_MAX-1:0]      tag;
  logic [WAYS-1:0]         vv;
  logic [WAYS-1:0]         hitv;
  logic [WAYS-1:0][AW-1:0] cur_age;
  logic [WAYS-1:0][AW-1:0] nxt_age;
  logic [AW-1:0]           victim;
  logic                    lk_hit;
  logic                    evict;

  assign idx = IW'((address >> OW) & ADDR_W'(SETS - 1));
  assign tag = TAG_MAX'(address >> (OW + IB));

  always_comb begin
    vv      = '0;
    hitv    = '0;
    cur_age = age[idx];
    for (int w = 0; w < WAYS; w++) begin
      vv[w]   = ent[idx][w].valid;
      hitv[w] = ent[idx][w].valid && (ent[idx][w].tag == tag);
    end
  end

  assign lk_hit = |hitv;
  assign evict  = !lk_hit && vv[victim];

  sa_cache_lru #(
    .WAYS(WAYS),
    .AW  (AW)
  ) u_lru (
    .ages    (cur_age),
    .valid   (vv),
    .hitv    (hitv),
    .nxt_ages(nxt_age),
    .victim  (victim)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ent[s][w] <= '0;
          age[s][w] <= AW'(w);
        end
      end
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      hitCount   <= '0;
      missCount  <= '0;
    end else begin
      resp_valid <= addr_valid;
      hit        <= addr_valid && lk_hit;
      miss       <= addr_valid && !lk_hit;
      if (addr_valid) begin
        age[idx] <= nxt_age;
        if (lk_hit) begin
          hitCount <= CNT_W'(sat_inc(64'(hitCount), CNT_W));
        end else begin
          ent[idx][victim] <= '{valid: 1'b1, tag: tag};
          missCount <= CNT_W'(sat_inc(64'(missCount), CNT_W));
        end
      end
    end
  end

`ifdef SA_CACHE_EVICT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      evictCount <= '0;
    else if (addr_valid && evict)
      evictCount <= CNT_W'(sat_inc(64'(evictCount), CNT_W));
  end
`else
  assign evictCount = '0;
  logic unused_evict;
  assign unused_evict = evict;
`endif

endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache: LRU, conflicts, idle, reset, saturation.
// Four instances cover 2-way, narrow counters, direct-mapped and 1-set.
module tb_sa_cache;

`ifdef SA_CACHE_EVICT_COUNT_EN
  localparam bit EVON = 1'b1;
`else
  localparam bit EVON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        v  [4];
  logic [31:0] a  [4];
  logic        rv [4];
  logic        hh [4];
  logic        mm [4];
  logic [31:0] hc [4];
  logic [31:0] mc [4];
  logic [31:0] ec [4];
  logic [3:0]  hc1, mc1, ec1;

  int total = 0;
  int bad   = 0;

  assign hc[1] = {28'b0, hc1};
  assign mc[1] = {28'b0, mc1};
  assign ec[1] = {28'b0, ec1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sa_cache #(.ADDR_W(32), .SETS(4), .WAYS(2), .BLOCK_BYTES(16), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .addr_valid(v[0]), .address(a[0]),
    .resp_valid(rv[0]), .hit(hh[0]), .miss(mm[0]),
    .hitCount(hc[0]), .missCount(mc[0]), .evictCount(ec[0]));

  sa_cache #(.ADDR_W(32), .SETS(4), .WAYS(2), .BLOCK_BYTES(16), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .addr_valid(v[1]), .address(a[1]),
    .resp_valid(rv[1]), .hit(hh[1]), .miss(mm[1]),
    .hitCount(hc1), .missCount(mc1), .evictCount(ec1));

  sa_cache #(.ADDR_W(32), .SETS(4), .WAYS(1), .BLOCK_BYTES(16), .CNT_W(32)) u2 (
    .clk(clk), .reset(reset), .addr_valid(v[2]), .address(a[2]),
    .resp_valid(rv[2]), .hit(hh[2]), .miss(mm[2]),
    .hitCount(hc[2]), .missCount(mc[2]), .evictCount(ec[2]));

  sa_cache #(.ADDR_W(32), .SETS(1), .WAYS(4), .BLOCK_BYTES(16), .CNT_W(32)) u3 (
    .clk(clk), .reset(reset), .addr_valid(v[3]), .address(a[3]),
    .resp_valid(rv[3]), .hit(hh[3]), .miss(mm[3]),
    .hitCount(hc[3]), .missCount(mc[3]), .evictCount(ec[3]));

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic go(input int k, input logic [31:0] ad,
                    input logic eh, input string t);
    v[k] = 1'b1;
    a[k] = ad;
    @(posedge clk);
    #1;
    v[k] = 1'b0;
    chk({t, ".rv"},   32'(rv[k]), 32'd1);
    chk({t, ".hit"},  32'(hh[k]), 32'(eh));
    chk({t, ".miss"}, 32'(mm[k]), 32'(!eh));
  endtask

  task automatic idle(input int k, input string t);
    v[k] = 1'b0;
    @(posedge clk);
    #1;
    chk({t, ".rv"},   32'(rv[k]), 32'd0);
    chk({t, ".hit"},  32'(hh[k]), 32'd0);
    chk({t, ".miss"}, 32'(mm[k]), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cnts(input int k, input string t, input int eh,
                      input int em, input int ee);
    chk({t, ".hits"},   hc[k], 32'(eh));
    chk({t, ".misses"}, mc[k], 32'(em));
    chk({t, ".evicts"}, ec[k], EVON ? 32'(ee) : 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v[k] = 1'b0;
      a[k] = '0;
    end
    @(posedge clk);
    do_reset();

    chk("rst.rv", 32'(rv[0]), 32'd0);
    cnts(0, "rst", 0, 0, 0);

    go(0, 32'h0000_0000, 1'b0, "t1.a0");
    go(0, 32'h0000_0004, 1'b1, "t1.a4");
    cnts(0, "t1", 1, 1, 0);

    do_reset();
    go(0, 32'h000, 1'b0, "t2.0");
    go(0, 32'h040, 1'b0, "t2.1");
    go(0, 32'h000, 1'b1, "t2.2");
    go(0, 32'h080, 1'b0, "t2.3");
    go(0, 32'h000, 1'b1, "t2.4");
    go(0, 32'h040, 1'b0, "t2.5");
    cnts(0, "t2", 2, 4, 2);

    go(0, 32'h000, 1'b1, "t3.0");
    idle(0, "t3.i0");
    go(0, 32'h040, 1'b1, "t3.1");
    idle(0, "t3.i1");
    idle(0, "t3.i2");
    cnts(0, "t3", 4, 4, 2);
    go(0, 32'h010, 1'b0, "t3.2");
    cnts(0, "t3b", 4, 5, 2);

    v[0] = 1'b1;
    a[0] = 32'h000;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    v[0] = 1'b0;
    chk("t4.rv", 32'(rv[0]), 32'd0);
    cnts(0, "t4", 0, 0, 0);
    go(0, 32'h000, 1'b0, "t4.a");
    cnts(0, "t4b", 0, 1, 0);

    for (int i = 0; i < 17; i++) begin
      go(1, 32'(i * 16), 1'b0, $sformatf("t5.%0d", i));
      if (i == 14) chk("t5.mc15", mc[1], 32'd15);
    end
    cnts(1, "t5", 0, 15, 9);

    go(2, 32'h000, 1'b0, "t6a.0");
    go(2, 32'h040, 1'b0, "t6a.1");
    go(2, 32'h000, 1'b0, "t6a.2");
    cnts(2, "t6a", 0, 3, 2);

    go(3, 32'h000, 1'b0, "t6b.0");
    go(3, 32'h040, 1'b0, "t6b.1");
    go(3, 32'h000, 1'b1, "t6b.2");
    cnts(3, "t6b", 1, 2, 0);

    do_reset();
    go(3, 32'h000, 1'b0, "t6c.0");
    go(3, 32'h010, 1'b0, "t6c.1");
    go(3, 32'h020, 1'b0, "t6c.2");
    go(3, 32'h030, 1'b0, "t6c.3");
    go(3, 32'h040, 1'b0, "t6c.4");
    cnts(3, "t6c", 0, 5, 1);
    go(3, 32'h000, 1'b0, "t6c.5");
    go(3, 32'h020, 1'b1, "t6c.6");
    go(3, 32'h010, 1'b0, "t6c.7");
    cnts(3, "t6d", 1, 7, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
